// File: rtl/cpu_defs_pkg.sv
// Shared CPU definitions: datapath widths, reset/NOP constants and fetch FSM states.
package cpu_defs;
  localparam int unsigned INS_W = 32;
  localparam int unsigned PC_W  = 32;

  localparam logic [INS_W-1:0] NOP_INS_DEF  = 32'h0000_0000;
  localparam logic [PC_W-1:0]  RESET_PC_DEF = 32'h0000_0000;

  typedef enum logic [1:0] {
    FETCH,
    HOLD,
    DISCARD
  } fetch_state_e;
endpackage

// File: rtl/if_stage_pc_reg.sv
// PC register: synchronous reset, +4 advance (wraps mod 2^32) and word-aligned load.
module pc_reg
  import cpu_defs::*;
#(
  parameter logic [PC_W-1:0] RESET_PC = RESET_PC_DEF
) (
  input  logic            clk,
  input  logic            i_reset,
  input  logic            i_load,
  input  logic [PC_W-1:0] i_load_pc,
  input  logic            i_inc,
  output logic [PC_W-1:0] o_pc
);
  logic [PC_W-1:0] r_pc;

  always_ff @(posedge clk) begin
    if (i_reset) begin
      r_pc <= RESET_PC;
    end else if (i_load) begin
      r_pc <= i_load_pc & ~PC_W'(3);
    end else if (i_inc) begin
      r_pc <= r_pc + PC_W'(4);
    end
  end

  assign o_pc = r_pc;
endmodule

// File: rtl/if_stage.sv
// IF stage: PC, req/ack instruction-memory port, one-entry skid buffer, redirect handling.
// Optional macro DELAY_SLOT_EN: the instruction following a redirect is kept as a delay slot.
module if_stage
  import cpu_defs::*;
#(
  parameter logic [PC_W-1:0]  RESET_PC = RESET_PC_DEF,
  parameter logic [INS_W-1:0] NOP_INS  = NOP_INS_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall_id,
  input  logic             redirect_valid,
  input  logic [PC_W-1:0]  redirect_pc,
  output logic             imem_req,
  output logic [PC_W-1:0]  imem_addr,
  input  logic             imem_ack,
  input  logic [INS_W-1:0] imem_rdata,
  output logic             id_valid,
  output logic [PC_W-1:0]  id_pc,
  output logic [INS_W-1:0] id_ins
);
  fetch_state_e     r_state, w_next_state;
  logic             r_req, w_req_next;
  logic [PC_W-1:0]  w_pc, w_tgt, r_tgt, w_load_pc;
  logic             w_pc_load, w_pc_inc, w_tgt_load;
  logic             w_id_mem, w_id_skid, w_id_flush, w_skid_load;
  logic [INS_W-1:0] r_skid_ins;
  logic             r_id_valid;
  logic [PC_W-1:0]  r_id_pc;
  logic [INS_W-1:0] r_id_ins;
`ifdef DELAY_SLOT_EN
  logic             r_ds_pending, w_ds_clr;
`endif

  assign w_tgt = redirect_pc & ~PC_W'(3);

  pc_reg #(.RESET_PC(RESET_PC)) u_pc_reg (
    .clk       (clk),
    .i_reset   (reset),
    .i_load    (w_pc_load),
    .i_load_pc (w_load_pc),
    .i_inc     (w_pc_inc),
    .o_pc      (w_pc)
  );

  always_ff @(posedge clk) begin
    if (reset) r_state <= FETCH;
    else       r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    w_req_next   = r_req;
    w_pc_load    = 1'b0;
    w_load_pc    = r_tgt;
    w_pc_inc     = 1'b0;
    w_tgt_load   = 1'b0;
    w_id_mem     = 1'b0;
    w_id_skid    = 1'b0;
    w_id_flush   = 1'b0;
    w_skid_load  = 1'b0;
`ifdef DELAY_SLOT_EN
    w_ds_clr     = 1'b0;
`endif
    case (r_state)
      FETCH: begin
        w_req_next = 1'b1;
        if (r_req && imem_ack) begin
          if (stall_id) begin
            w_skid_load  = 1'b1;
            w_req_next   = 1'b0;
            w_next_state = HOLD;
          end else begin
            w_id_mem = 1'b1;
            w_pc_inc = 1'b1;
          end
        end else if (!stall_id) begin
          w_id_flush = 1'b1;
        end
      end
      HOLD: begin
        if (!stall_id) begin
          w_id_skid    = 1'b1;
          w_pc_inc     = 1'b1;
          w_req_next   = 1'b1;
          w_next_state = FETCH;
        end
      end
      DISCARD: begin
        if (!stall_id) w_id_flush = 1'b1;
        if (imem_ack) begin
          w_pc_load    = 1'b1;
          w_next_state = FETCH;
        end
      end
      default: w_next_state = FETCH;
    endcase
`ifdef DELAY_SLOT_EN
    if (redirect_valid) w_tgt_load = 1'b1;
    // Delivering the slot instruction is what steers pc to the saved target.
    if (w_pc_inc && (redirect_valid || r_ds_pending)) begin
      w_pc_inc  = 1'b0;
      w_pc_load = 1'b1;
      w_load_pc = redirect_valid ? w_tgt : r_tgt;
      w_ds_clr  = 1'b1;
    end
`else
    if (redirect_valid) begin
      w_id_mem    = 1'b0;
      w_id_skid   = 1'b0;
      w_skid_load = 1'b0;
      w_pc_inc    = 1'b0;
      w_id_flush  = 1'b1;
      w_req_next  = 1'b1;
      if (r_req && !imem_ack) begin
        w_next_state = DISCARD;
        w_tgt_load   = 1'b1;
        w_pc_load    = 1'b0;
      end else begin
        w_next_state = FETCH;
        w_pc_load    = 1'b1;
        w_load_pc    = w_tgt;
      end
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_req      <= 1'b0;
      r_id_valid <= 1'b0;
      r_id_pc    <= '0;
      r_id_ins   <= NOP_INS;
      r_skid_ins <= NOP_INS;
      r_tgt      <= RESET_PC;
    end else begin
      r_req <= w_req_next;
      if (w_id_flush) begin
        r_id_valid <= 1'b0;
        r_id_ins   <= NOP_INS;
      end else if (w_id_mem) begin
        r_id_valid <= 1'b1;
        r_id_pc    <= w_pc;
        r_id_ins   <= imem_rdata;
      end else if (w_id_skid) begin
        r_id_valid <= 1'b1;
        r_id_pc    <= w_pc;
        r_id_ins   <= r_skid_ins;
      end
      if (w_skid_load) r_skid_ins <= imem_rdata;
      if (w_tgt_load)  r_tgt      <= w_tgt;
    end
  end

`ifdef DELAY_SLOT_EN
  always_ff @(posedge clk) begin
    if (reset)               r_ds_pending <= 1'b0;
    else if (w_ds_clr)       r_ds_pending <= 1'b0;
    else if (redirect_valid) r_ds_pending <= 1'b1;
  end
`endif

  assign imem_req  = r_req;
  assign imem_addr = w_pc;
  assign id_valid  = r_id_valid;
  assign id_pc     = r_id_pc;
  assign id_ins    = r_id_ins;
endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: directed fetch scenarios plus randomized
// stall/ack/redirect/reset traffic compared every cycle against a fetch model.
module tb_if_stage;
  localparam logic [31:0] K   = 32'hA5A5_0000;
  localparam logic [31:0] NOP = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset, stall_id, redirect_valid, imem_ack;
  logic [31:0] redirect_pc, imem_addr, imem_rdata, id_pc, id_ins;
  logic        imem_req, id_valid;
  int          pass_cnt = 0;
  int          total_cnt = 0;

  // Model: the fetch address, whether its data is to be thrown away, a held word, IF/ID contents.
  logic        m_req, m_id_valid, m_held, m_dropping, m_ds_pend;
  logic [31:0] m_addr, m_id_pc, m_id_ins, m_held_ins, m_drop_tgt, m_ds_tgt;

  if_stage #(.RESET_PC(32'h0000_0000), .NOP_INS(NOP)) dut (
    .clk            (clk),
    .reset          (reset),
    .stall_id       (stall_id),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ack       (imem_ack),
    .imem_rdata     (imem_rdata),
    .id_valid       (id_valid),
    .id_pc          (id_pc),
    .id_ins         (id_ins)
  );

  always #5 clk = ~clk;
  assign imem_rdata = imem_addr ^ K;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic m_deliver(input logic [31:0] pc, input logic [31:0] ins);
    m_id_valid = 1'b1;
    m_id_pc    = pc;
    m_id_ins   = ins;
  endtask

  task automatic m_bubble();
    m_id_valid = 1'b0;
    m_id_ins   = NOP;
  endtask

  // Advance the model by one clock edge using the inputs that were present at that edge.
  task automatic model_step();
    logic [31:0] word, tgt, nxt;
    word = m_addr ^ K;
    tgt  = redirect_pc & ~32'd3;
    if (reset) begin
      m_req = 1'b0; m_addr = 32'h0; m_id_pc = 32'h0; m_held = 1'b0;
      m_dropping = 1'b0; m_ds_pend = 1'b0; m_ds_tgt = 32'h0;
      m_bubble();
    end else begin
`ifndef DELAY_SLOT_EN
      if (redirect_valid) begin
        m_bubble();
        m_held = 1'b0;
        if (m_req && !imem_ack) begin
          m_dropping = 1'b1;
          m_drop_tgt = tgt;
        end else begin
          m_dropping = 1'b0;
          m_addr     = tgt;
        end
        m_req = 1'b1;
      end else begin
`else
      begin
        if (redirect_valid) begin
          m_ds_pend = 1'b1;
          m_ds_tgt  = tgt;
        end
`endif
        nxt = m_ds_pend ? m_ds_tgt : m_addr + 32'd4;
        if (m_dropping) begin
          if (!stall_id) m_bubble();
          if (imem_ack) begin
            m_addr     = m_drop_tgt;
            m_dropping = 1'b0;
          end
        end else if (m_held) begin
          if (!stall_id) begin
            m_deliver(m_addr, m_held_ins);
            m_held = 1'b0; m_req = 1'b1; m_addr = nxt; m_ds_pend = 1'b0;
          end
        end else if (m_req && imem_ack) begin
          if (stall_id) begin
            m_held = 1'b1; m_held_ins = word; m_req = 1'b0;
          end else begin
            m_deliver(m_addr, word);
            m_addr = nxt; m_ds_pend = 1'b0;
          end
        end else begin
          m_req = 1'b1;
          if (!stall_id) m_bubble();
        end
      end
    end
  endtask

  initial forever begin
    @(negedge clk);
    model_step();
    check("model imem_req", imem_req, m_req);
    check("model imem_addr", imem_addr, m_addr);
    check("model id_valid", id_valid, m_id_valid);
    check("model id_pc", id_pc, m_id_pc);
    check("model id_ins", id_ins, m_id_ins);
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic drive(input logic r, input logic s, input logic rv,
                       input logic [31:0] rpc, input logic a);
    reset = r; stall_id = s; redirect_valid = rv; redirect_pc = rpc; imem_ack = a;
  endtask

  task automatic wait_addr(input logic [31:0] a);
    for (int i = 0; i < 64 && imem_addr !== a; i++) tick();
    check("reach addr", imem_addr, a);
  endtask

  initial begin
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    tick(); tick();
    check("rst req", imem_req, 1'b0);
    check("rst addr", imem_addr, 32'h0);
    check("rst id_valid", id_valid, 1'b0);
    check("rst id_pc", id_pc, 32'h0);
    check("rst id_ins", id_ins, NOP);

    // Zero-wait memory after reset release.
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    tick();
    check("zw1 req", imem_req, 1'b1);
    check("zw1 addr", imem_addr, 32'h0);
    check("zw1 id_valid", id_valid, 1'b0);
    tick();
    check("zw2 addr", imem_addr, 32'h4);
    check("zw2 id_valid", id_valid, 1'b1);
    check("zw2 id_pc", id_pc, 32'h0);
    check("zw2 id_ins", id_ins, 32'hA5A5_0000);
    tick();
    check("zw3 addr", imem_addr, 32'h8);
    check("zw3 id_pc", id_pc, 32'h4);
    check("zw3 id_ins", id_ins, 32'hA5A5_0004);

    // Three-cycle ack delay on 0x10.
    wait_addr(32'h10);
    imem_ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("delay addr", imem_addr, 32'h10);
      check("delay id_valid", id_valid, 1'b0);
    end
    imem_ack = 1'b1;
    tick();
    check("delay id_pc", id_pc, 32'h10);
    check("delay id_valid after", id_valid, 1'b1);
    check("delay next addr", imem_addr, 32'h14);

    // Decode stall while 0x20 is acked.
    wait_addr(32'h20);
    stall_id = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("stall req", imem_req, 1'b0);
      check("stall id_pc", id_pc, 32'h1C);
    end
    stall_id = 1'b0;
    tick();
    check("unstall id_pc", id_pc, 32'h20);
    check("unstall id_ins", id_ins, 32'hA5A5_0020);
    check("unstall addr", imem_addr, 32'h24);
    check("unstall req", imem_req, 1'b1);

`ifndef DELAY_SLOT_EN
    // Redirect while 0x40 is outstanding; its data must be dropped.
    wait_addr(32'h40);
    drive(1'b0, 1'b0, 1'b1, 32'h103, 1'b0);
    tick();
    check("redir id_valid", id_valid, 1'b0);
    redirect_valid = 1'b0;
    tick();
    check("redir wait addr", imem_addr, 32'h40);
    imem_ack = 1'b1;
    tick();
    check("redir target addr", imem_addr, 32'h100);
    check("redir drop id_valid", id_valid, 1'b0);
    tick();
    check("redir id_pc", id_pc, 32'h100);
    check("redir id_ins", id_ins, 32'hA5A5_0100);
`else
    // Delay slot: in-flight 0x84 is still delivered before the jump to 0x200.
    wait_addr(32'h84);
    drive(1'b0, 1'b0, 1'b1, 32'h200, 1'b0);
    tick();
    check("ds addr hold", imem_addr, 32'h84);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    tick();
    check("ds id_valid", id_valid, 1'b1);
    check("ds id_pc", id_pc, 32'h84);
    check("ds target addr", imem_addr, 32'h200);
`endif

    // Wrap of pc+4 at the top of the address space; low target bits are masked.
    drive(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b1);
    tick();
    redirect_valid = 1'b0;
    check("wrap addr", imem_addr, 32'hFFFF_FFFC);
    tick();
    check("wrap next addr", imem_addr, 32'h0);
    check("wrap id_pc", id_pc, 32'hFFFF_FFFC);

    // Randomized traffic; every cycle is checked by the model process.
    for (int n = 0; n < 4000; n++) begin
      reset          = ($urandom_range(199) == 0);
      stall_id       = ($urandom_range(99) < 30);
      imem_ack       = ($urandom_range(99) < 55);
      redirect_valid = ($urandom_range(99) < 6);
      redirect_pc    = ($urandom_range(3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15)))
                                                : $urandom;
      tick();
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction-fetch stage of the 5-stage MIPS pipeline, directly upstream of the decode stage.
- Owns the PC register and drives a req/ack instruction-memory port with variable latency.
- Registers {pc, ins} into the IF/ID boundary that feeds decode's pc and ins inputs.
- Absorbs a decode-side stall through a one-entry skid buffer and handles control-flow redirects, including discarding in-flight fetches.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset; first fetch address.
- NOP_INS, 32'h0000_0000, instruction word presented to decode when id_valid=0 (sll $0,$0,0).

Ports:
- clk  in  1  pipeline clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- stall_id  in  1  decode cannot accept a new instruction this cycle.
- redirect_valid  in  1  control-flow change request.
- redirect_pc  in  32  target PC; bits [1:0] forced to 00 internally.
- imem_req  out  1  fetch request.
- imem_addr  out  32  fetch address; word aligned.
- imem_ack  in  1  memory returns data this cycle; meaningful only while imem_req=1.
- imem_rdata  in  32  instruction word; valid when imem_ack=1.
- id_valid  out  1  id_pc/id_ins hold a real instruction.
- id_pc  out  32  PC of the instruction at the IF/ID boundary.
- id_ins  out  32  instruction word to decode.

Behaviour:
- Reset, evaluated at the clock edge while reset=1:
  - pc=RESET_PC, state=FETCH.
  - imem_req=0, imem_addr=RESET_PC.
  - id_valid=0, id_pc=0, id_ins=NOP_INS.
  - Skid buffer cleared.
  - Reset asserted mid-transaction abandons the outstanding request; an ack arriving with req=0 is ignored.
- Handshake:
  - imem_req is registered.
  - While imem_req=1, imem_addr is stable until the cycle in which imem_ack=1.
  - Transfer completes on an edge where imem_req&imem_ack.
  - Zero-wait memory (ack in the first req cycle) sustains one instruction per cycle: req stays high and addr advances to pc+4 on the next cycle.
- State machine FETCH / HOLD / DISCARD:
  - FETCH, req=1:
    - On ack with stall_id=0: id_valid<=1, id_pc<=imem_addr, id_ins<=imem_rdata, pc<=pc+4.
    - On ack with stall_id=1: the word goes into the skid buffer; req<=0; go to HOLD.
  - HOLD, req=0: when stall_id=0, the buffer moves to the id registers, pc<=pc+4, req<=1, go to FETCH.
  - DISCARD, req=1 with the old address: wait for ack, drop the returned data, then fetch from the saved redirect target in FETCH.
- Stall with no buffered data: the id registers hold their values; a fetch may proceed and fill the buffer.
- Redirect (redirect_valid=1), highest priority over stall and ack:
  - id_valid<=0, id_ins<=NOP_INS; skid buffer cleared.
  - pc<=redirect_pc&~3.
  - If a request is outstanding without ack this cycle, go to DISCARD.
  - Otherwise go to FETCH with imem_addr=target next cycle.
  - An ack coinciding with redirect is dropped.
- Arithmetic: pc+4 wraps modulo 2^32 (32'hFFFF_FFFC -> 0); no overflow flag.
- Simultaneous redirect and reset: reset wins.
- Latency: a word acked on edge N is visible on id_* after edge N. Redirect to first fetch request is 1 cycle.

Optional Feature:
- Macro: DELAY_SLOT_EN.
- Defined (MIPS branch-delay-slot semantics):
  - The first instruction after the one in IF/ID at redirect time is not flushed, whether it is buffered, acked in the redirect cycle, or still outstanding. It is delivered to decode with id_pc = old pc.
  - Only then is pc loaded with the target; the target is saved until the slot instruction is delivered.
  - DISCARD is never entered for the slot fetch.
- Undefined: redirect flushes everything as described above.

Decomposition:
- Shared package cpu_defs holds:
  - INS_W=32, PC_W=32.
  - NOP_INS.
  - RESET_PC default.
  - Fetch state enum {FETCH, HOLD, DISCARD}.
- One natural sub-module, pc_reg: PC register with reset, +4 increment, redirect load and alignment masking.
- FSM and skid buffer live in if_stage.

Test Plan:
- Reset release, zero-wait memory returning ins=addr^32'hA5A5_0000:
  - imem_addr 0,4,8,... on consecutive cycles.
  - id_pc lags by 1 cycle; id_valid=1 from the second cycle after reset.
- ack delayed 3 cycles on addr 0x10: imem_addr stays 0x10 for 3 cycles, then id_pc=0x10; no duplicate or skipped fetch.
- stall_id=1 for 4 cycles while ack arrives at addr 0x20:
  - imem_req drops; id_* unchanged.
  - On release, id_pc=0x20 with the buffered word, then fetch 0x24.
- redirect_pc=0x103 while a request to 0x40 is outstanding with ack 2 cycles later:
  - id_valid=0 next cycle; the 0x40 data is never presented.
  - Next imem_addr=0x100.
- PC at 0xFFFF_FFFC, zero-wait: next imem_addr=0x0000_0000.
- With DELAY_SLOT_EN, redirect to 0x200 while in-flight addr is 0x84: id_pc=0x84 is delivered with id_valid=1, then imem_addr=0x200. Without the macro, 0x84 is dropped.
